// File: rtl/adpcm_pkg.sv
// Shared ADPCM predictor constants, FSM encoding and small helpers.
package adpcm_pkg;

  localparam int unsigned N_ZERO = 6;
  localparam int unsigned N_POLE = 2;
  localparam int unsigned N_TAPS = N_ZERO + N_POLE;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned FLT_W  = 11;
  localparam int unsigned SE_W   = 15;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of significant bits in a 13-bit magnitude (0 for zero).
  function automatic logic [3:0] bit_len13(input logic [12:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (v[i]) n = 4'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/fmult_accum_seq_if.sv
// Request/result bundle between the predictor engine and its requester.
interface fmult_accum_seq_if;
  import adpcm_pkg::*;

  logic                     start;
  logic [N_TAPS*COEF_W-1:0] coef;
  logic [N_TAPS*FLT_W-1:0]  flt;
  logic                     busy;
  logic                     done;
  logic [SE_W-1:0]          sez;
  logic [SE_W-1:0]          se;

  modport master (output start, coef, flt, input busy, done, sez, se);
  modport slave  (input start, coef, flt, output busy, done, sez, se);
endinterface

// File: rtl/fmult_accum_seq_fmult.sv
// G.726 FMULT: coefficient (An) times float operand (SRn/DQn), purely combinational.
module fmult_accum_seq_fmult
  import adpcm_pkg::*;
(
  input  logic [COEF_W-1:0] an_i,
  input  logic [FLT_W-1:0]  srn_i,
  output logic [COEF_W-1:0] wan_o_c
);

  logic        an_s;
  logic [12:0] an_mag;
  logic [3:0]  an_exp;
  logic [5:0]  an_mant;
  logic [4:0]  wa_exp;
  logic [11:0] prod;
  logic [7:0]  wa_mant;
  logic [14:0] wa_base;
  logic [14:0] wa_mag;

  always_comb begin
    an_s    = an_i[15];
    // Magnitude of An/4 in 13 bits; negation modulo 2^13 matches the reference mask.
    an_mag  = an_s ? (13'd0 - an_i[14:2]) : an_i[14:2];
    an_exp  = bit_len13(an_mag);
    an_mant = (an_mag == 13'd0) ? 6'd32 : 6'({an_mag, 6'b0} >> an_exp);
    wa_exp  = 5'(an_exp) + 5'(srn_i[9:6]);
    prod    = 12'(an_mant) * 12'(srn_i[5:0]);
    wa_mant = 8'((prod + 12'd48) >> 4);
    wa_base = {wa_mant, 7'b0};
    wa_mag  = (wa_exp <= 5'd26) ? (wa_base >> (5'd26 - wa_exp))
                                : (wa_base << (wa_exp - 5'd26));
    wan_o_c = (an_s ^ srn_i[10]) ? (16'd0 - {1'b0, wa_mag}) : {1'b0, wa_mag};
  end

endmodule

// File: rtl/fmult_accum_seq.sv
// Time-multiplexed predictor: one FMULT and a 16-bit accumulator walk taps B1..B6, A1, A2
// to produce SEZ (after B6) and SE (after A2).
module fmult_accum_seq
  import adpcm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fmult_accum_seq_if.slave  bus_if
);

  state_e                   state_q;
  logic [IDX_W-1:0]         idx_q;
  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         acc_d;
  logic [COEF_W-1:0]        wan;
  logic [SE_W-1:0]          sezi_q;
  logic [SE_W-1:0]          sez_q;
  logic [SE_W-1:0]          se_q;
  logic [N_TAPS*COEF_W-1:0] coef_q;
  logic [N_TAPS*FLT_W-1:0]  flt_q;
  logic                     busy_q;
  logic                     done_q;
  logic [COEF_W-1:0]        an_sel;
  logic [FLT_W-1:0]         srn_sel;

  // Tap select follows bus order, so idx 0..7 is B1..B6, A1, A2.
  assign an_sel  = coef_q[32'(idx_q) * COEF_W +: COEF_W];
  assign srn_sel = flt_q[32'(idx_q) * FLT_W +: FLT_W];
  assign acc_d   = acc_q + wan;

  fmult_accum_seq_fmult u_fmult (
    .an_i    (an_sel),
    .srn_i   (srn_sel),
    .wan_o_c (wan)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      sezi_q  <= '0;
      sez_q   <= '0;
      se_q    <= '0;
      coef_q  <= '0;
      flt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus_if.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            acc_q   <= '0;
            coef_q  <= bus_if.coef;
            flt_q   <= bus_if.flt;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N_ZERO - 1)) sezi_q <= acc_d[ACC_W-1:1];
          if (idx_q == IDX_W'(N_TAPS - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sez_q   <= sezi_q;
            se_q    <= acc_d[ACC_W-1:1];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.busy = busy_q;
  assign bus_if.done = done_q;
  assign bus_if.sez  = sez_q;
  assign bus_if.se   = se_q;

endmodule

// File: tb/tb_fmult_accum_seq.sv
// Directed and randomized bench for fmult_accum_seq against an arithmetic G.726 reference.
module tb_fmult_accum_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fmult_accum_seq_if bus ();

  fmult_accum_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // G.726 FMULT written directly from the recommendation's integer formulas.
  function automatic int ref_fmult(input int an, input int srn);
    int an_s, an_mag, an_exp, an_mant, sr_s, sr_exp, sr_mant, wa_exp, wa_mant, wa_mag;
    an_s    = (an >> 15) & 1;
    an_mag  = an_s ? ((16384 - (an >> 2)) & 8191) : (an >> 2);
    an_exp  = 0;
    while ((an_mag >> an_exp) != 0) an_exp++;
    an_mant = (an_mag == 0) ? 32 : ((an_mag << 6) >> an_exp);
    sr_s    = (srn >> 10) & 1;
    sr_exp  = (srn >> 6) & 15;
    sr_mant = srn & 63;
    wa_exp  = sr_exp + an_exp;
    wa_mant = ((sr_mant * an_mant) + 48) >> 4;
    wa_mag  = (wa_exp <= 26) ? ((wa_mant << 7) >> (26 - wa_exp))
                             : (((wa_mant << 7) << (wa_exp - 26)) & 32767);
    return (sr_s ^ an_s) ? ((65536 - wa_mag) & 65535) : wa_mag;
  endfunction

  task automatic ref_op(input logic [127:0] c, input logic [87:0] f,
                        output logic [14:0] sez, output logic [14:0] se);
    int sum;
    sum = 0;
    sez = '0;
    for (int k = 0; k < 8; k++) begin
      sum = (sum + ref_fmult(int'(c[k*16 +: 16]), int'(f[k*11 +: 11]))) % 65536;
      if (k == 5) sez = 15'(sum >> 1);
    end
    se = 15'(sum >> 1);
  endtask

  function automatic logic [127:0] rnd_coef();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [87:0] rnd_flt();
    return 88'({$urandom, $urandom, $urandom});
  endfunction

  task automatic run_op(input string tag, input logic [127:0] c, input logic [87:0] f,
                        input logic [14:0] exp_sez, input logic [14:0] exp_se);
    int lat;
    bit seen;
    @(negedge clk);
    bus.coef  = c;
    bus.flt   = f;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.coef  = rnd_coef();
    bus.flt   = rnd_flt();
    check($sformatf("%s busy", tag), 32'(bus.busy), 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.done) seen = 1'b1;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'd8);
    check($sformatf("%s sez", tag), 32'(bus.sez), 32'(exp_sez));
    check($sformatf("%s se", tag), 32'(bus.se), 32'(exp_se));
    check($sformatf("%s busy_at_done", tag), 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    check($sformatf("%s done_pulse", tag), 32'(bus.done), 32'd0);
    check($sformatf("%s sez_hold", tag), 32'(bus.sez), 32'(exp_sez));
    check($sformatf("%s se_hold", tag), 32'(bus.se), 32'(exp_se));
  endtask

  initial begin
    logic [127:0] c;
    logic [87:0]  f;
    logic [14:0]  rs, re;
    logic [127:0] hc [3];
    logic [87:0]  hf [3];
    logic [14:0]  hs [3];
    logic [14:0]  he [3];
    int dn;

    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.coef  = '0;
    bus.flt   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst sez", 32'(bus.sez), 32'd0);
    check("rst se", 32'(bus.se), 32'd0);

    // Eight equal products 0x2180: SEI = 68608 wraps to 0x0C00.
    run_op("all_taps", {8{16'h4000}}, {8{11'h360}}, 15'h6480, 15'h0600);
    run_op("a1_pos", {16'h0, 16'h4000, 96'h0}, {11'h0, 11'h360, 66'h0}, 15'h0000, 15'h10C0);
    run_op("a1_neg", {16'h0, 16'hC000, 96'h0}, {11'h0, 11'h360, 66'h0}, 15'h0000, 15'h6F40);
    // Zero coefficients still yield a product of 1 per tap through the mant=32 rule.
    run_op("zero_coef", 128'h0, {8{11'h360}}, 15'h0003, 15'h0004);

    // Abort at E4 with an asynchronous reset.
    @(negedge clk);
    bus.coef  = {8{16'h4000}};
    bus.flt   = {8{11'h360}};
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort sez", 32'(bus.sez), 32'd0);
    check("abort se", 32'(bus.se), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("abort no_done", 32'(dn), 32'd0);

    // start held high for 30 cycles: operands only matter at E0, E9, E18.
    for (int i = 0; i < 3; i++) begin
      hc[i] = rnd_coef();
      hf[i] = rnd_flt();
      ref_op(hc[i], hf[i], hs[i], he[i]);
    end
    dn = 0;
    @(negedge clk);
    for (int t = 0; t < 30; t++) begin
      if (t % 9 == 0 && t < 27) begin
        bus.coef = hc[t/9];
        bus.flt  = hf[t/9];
      end else begin
        bus.coef = rnd_coef();
        bus.flt  = rnd_flt();
      end
      bus.start = 1'b1;
      @(negedge clk);
      if (bus.done) dn++;
      if (t % 9 == 8) begin
        check($sformatf("held done t=%0d", t), 32'(bus.done), 32'd1);
        check($sformatf("held sez t=%0d", t), 32'(bus.sez), 32'(hs[t/9]));
        check($sformatf("held se t=%0d", t), 32'(bus.se), 32'(he[t/9]));
        check($sformatf("held busy t=%0d", t), 32'(bus.busy), 32'd0);
      end else begin
        check($sformatf("held done t=%0d", t), 32'(bus.done), 32'd0);
        check($sformatf("held busy t=%0d", t), 32'(bus.busy), 32'd1);
      end
    end
    bus.start = 1'b0;
    check("held pulse_count", 32'(dn), 32'd3);
    repeat (12) @(negedge clk);

    // Randomized operations against the reference.
    for (int n = 0; n < 20; n++) begin
      c = rnd_coef();
      f = rnd_flt();
      ref_op(c, f, rs, re);
      run_op($sformatf("rand%0d", n), c, f, rs, re);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
